// File: rtl/modbus_func_engine_if.sv
// Bus between the Modbus function engine and its frame receiver, register file,
// TX DPRAM and response transmitter. slave = engine side, master = surrounding logic.
interface modbus_func_engine_if #(
  parameter int N_HOLD   = 8,
  parameter int N_INPUT  = 8,
  parameter int DPRAM_AW = 8
);
  logic                    rx_message_done;
  logic [7:0]              func_code;
  logic [15:0]             addr;
  logic [15:0]             data;
  logic                    exception_done;
  logic [7:0]              exception_in;
  logic [16*N_HOLD-1:0]    hold_regs;
  logic [16*N_INPUT-1:0]   input_regs;
  logic [7:0]              tx_quantity;
  logic [7:0]              exception_out;
  logic [7:0]              func_code_r;
  logic [15:0]             addr_r;
  logic [15:0]             data_r;
  logic                    dpram_wen;
  logic [DPRAM_AW-1:0]     dpram_addr;
  logic [15:0]             dpram_wdata;
  logic                    reg_wen;
  logic [15:0]             reg_waddr;
  logic [15:0]             reg_wdat;
  logic                    reg_w_done;
  logic                    reg_w_status;
  logic                    handler_done;
  logic                    busy;

  modport master (
    output rx_message_done, func_code, addr, data, exception_done, exception_in,
           hold_regs, input_regs, reg_w_done, reg_w_status,
    input  tx_quantity, exception_out, func_code_r, addr_r, data_r, dpram_wen,
           dpram_addr, dpram_wdata, reg_wen, reg_waddr, reg_wdat, handler_done, busy
  );

  modport slave (
    input  rx_message_done, func_code, addr, data, exception_done, exception_in,
           hold_regs, input_regs, reg_w_done, reg_w_status,
    output tx_quantity, exception_out, func_code_r, addr_r, data_r, dpram_wen,
           dpram_addr, dpram_wdata, reg_wen, reg_waddr, reg_wdat, handler_done, busy
  );
endinterface

// File: rtl/modbus_func_engine.sv
// Modbus RTU function handler for FC 03/04 (register reads into TX DPRAM) and FC 06 (write handshake).
// Optional macro MODBUS_WR_TIMEOUT_EN bounds the wait for reg_w_done to WR_TIMEOUT cycles.
module modbus_func_engine #(
  parameter int          N_HOLD     = 8,
  parameter int          N_INPUT    = 8,
  parameter logic [15:0] HOLD_BASE  = 16'h0001,
  parameter logic [15:0] INPUT_BASE = 16'h0001,
  parameter int          DPRAM_AW   = 8,
  parameter int          WR_TIMEOUT = 1000
) (
  input logic                clk_in,
  input logic                rst_n_in,
  modbus_func_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE_REQ, WRITE_WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  func_code_r, exception_out, tx_quantity, idx, chk_exc;
  logic [15:0] addr_r, data_r, reg_waddr, reg_wdat, rd_off, rd_word;
  logic [16:0] q17, a17, base17, n17;
  logic        is_rd, is_wr, last_word, wr_timeout;

  function automatic logic [15:0] word_at(input logic [2047:0] v, input logic [15:0] k);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < 128; i++)
      if (k == 16'(i)) w = v[16*i +: 16];
    return w;
  endfunction

  // Range checks use 17-bit arithmetic so addr + quantity cannot wrap past 0xFFFF.
  always_comb begin
    is_rd   = (func_code_r == 8'h03) || (func_code_r == 8'h04);
    is_wr   = (func_code_r == 8'h06);
    q17     = {1'b0, data_r};
    a17     = {1'b0, addr_r};
    base17  = (func_code_r == 8'h04) ? {1'b0, INPUT_BASE} : {1'b0, HOLD_BASE};
    n17     = (func_code_r == 8'h04) ? 17'(N_INPUT) : 17'(N_HOLD);
    chk_exc = 8'h00;
    if (!is_rd && !is_wr)
      chk_exc = 8'h01;
    else if (is_rd) begin
      if (q17 == 17'd0 || q17 > n17)
        chk_exc = 8'h03;
      else if (a17 < base17 || a17 + q17 > base17 + n17)
        chk_exc = 8'h02;
    end else if (a17 < base17 || a17 >= base17 + n17)
      chk_exc = 8'h02;
  end

  always_comb begin
    rd_off    = addr_r - base17[15:0] + {8'h00, idx};
    rd_word   = (func_code_r == 8'h04) ? word_at(2048'(bus.input_regs), rd_off)
                                       : word_at(2048'(bus.hold_regs), rd_off);
    last_word = ({8'h00, idx} == data_r - 16'd1);
  end

`ifdef MODBUS_WR_TIMEOUT_EN
  logic [15:0] wr_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || state != WRITE_WAIT) wr_cnt <= 16'd0;
    else                                  wr_cnt <= wr_cnt + 16'd1;
  end

  assign wr_timeout = (state == WRITE_WAIT) && (wr_cnt == 16'(WR_TIMEOUT - 1));
`else
  assign wr_timeout = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.exception_done)
                    state_nxt = (bus.exception_in != 8'h00) ? DONE : CHECK;
      CHECK:      state_nxt = (chk_exc != 8'h00) ? DONE : (is_rd ? READ : WRITE_REQ);
      READ:       if (last_word) state_nxt = DONE;
      WRITE_REQ:  state_nxt = WRITE_WAIT;
      WRITE_WAIT: if (bus.reg_w_done || wr_timeout) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Registered response fields; they hold across DONE/IDLE until the next transaction.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      func_code_r   <= 8'h00;
      addr_r        <= 16'h0000;
      data_r        <= 16'h0000;
      exception_out <= 8'h00;
      tx_quantity   <= 8'h00;
      reg_waddr     <= 16'h0000;
      reg_wdat      <= 16'h0000;
      idx           <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_message_done) begin
            func_code_r <= bus.func_code;
            addr_r      <= bus.addr;
            data_r      <= bus.data;
          end
          if (bus.exception_done && bus.exception_in != 8'h00)
            exception_out <= bus.exception_in;
        end
        CHECK: begin
          idx <= 8'h00;
          if (chk_exc != 8'h00) begin
            exception_out <= chk_exc;
            tx_quantity   <= 8'h00;
          end else if (is_wr) begin
            reg_waddr <= addr_r - HOLD_BASE;
            reg_wdat  <= data_r;
          end
        end
        READ: begin
          if (last_word) begin
            tx_quantity   <= data_r[7:0];
            exception_out <= 8'h00;
          end else
            idx <= idx + 8'd1;
        end
        WRITE_WAIT: begin
          if (bus.reg_w_done) begin
            exception_out <= bus.reg_w_status ? 8'h04 : 8'h00;
            tx_quantity   <= 8'h00;
          end else if (wr_timeout) begin
            exception_out <= 8'h04;
            tx_quantity   <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.func_code_r   = func_code_r;
  assign bus.addr_r        = addr_r;
  assign bus.data_r        = data_r;
  assign bus.exception_out = exception_out;
  assign bus.tx_quantity   = tx_quantity;
  assign bus.reg_waddr     = reg_waddr;
  assign bus.reg_wdat      = reg_wdat;
  assign bus.reg_wen       = (state == WRITE_REQ);
  assign bus.dpram_wen     = (state == READ);
  assign bus.dpram_addr    = DPRAM_AW'(idx);
  assign bus.dpram_wdata   = (state == READ) ? rd_word : 16'h0000;
  assign bus.handler_done  = (state == DONE);
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_modbus_func_engine.sv
// Bench for modbus_func_engine: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_modbus_func_engine;
  localparam int NH = 8;
  localparam int NI = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modbus_func_engine_if #(.N_HOLD(NH), .N_INPUT(NI), .DPRAM_AW(AW)) bus ();

  modbus_func_engine #(
    .N_HOLD(NH), .N_INPUT(NI), .HOLD_BASE(16'h0001), .INPUT_BASE(16'h0001),
    .DPRAM_AW(AW), .WR_TIMEOUT(20)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
  );

  logic [15:0] hreg [NH];
  logic [15:0] ireg [NI];
  for (genvar k = 0; k < NH; k++) begin : g_h
    assign bus.hold_regs[16*k +: 16] = hreg[k];
  end
  for (genvar k = 0; k < NI; k++) begin : g_i
    assign bus.input_regs[16*k +: 16] = ireg[k];
  end

  int n_total = 0;
  int n_pass  = 0;

  // Observations from the last transaction
  int          lat, nwr, nwen, hd_w;
  bit          aborted;
  logic [15:0] mem [256];
  logic [15:0] waddr_seen, wdat_seen;

  // Reference model state and expectations
  int          m_txq = 0;
  int          exp_exc, exp_txq, exp_lat, exp_nwr, exp_nwen, exp_waddr, exp_wdat, exp_base;
  bit          exp_from_input;

  typedef struct {
    logic [7:0]  fc;
    logic [15:0] a;
    logic [15:0] d;
    logic [7:0]  ex;
    bit          wst;
    int          e_exc, e_txq, e_lat, e_nwr, e_nwen;
    logic [15:0] e_w0, e_w1;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_txn(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] ex, input int wdelay, input bit wst,
                         input int inject_t, input int rst_t);
    int t, cd;
    bit done;
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    lat = -1; nwr = 0; nwen = 0; hd_w = 0; aborted = 0; cd = 0;
    waddr_seen = 16'h0; wdat_seen = 16'h0;
    bus.func_code = fc; bus.addr = a; bus.data = d;
    bus.rx_message_done = 1'b1; bus.reg_w_status = wst;
    @(negedge clk);
    bus.rx_message_done = 1'b0;
    bus.exception_in = ex; bus.exception_done = 1'b1;
    t = 0; done = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      bus.exception_done = 1'b0; bus.rx_message_done = 1'b0; bus.reg_w_done = 1'b0;
      if (bus.dpram_wen) begin
        mem[bus.dpram_addr] = bus.dpram_wdata;
        nwr++;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.reg_w_done = 1'b1;
      end
      if (bus.reg_wen) begin
        nwen++; waddr_seen = bus.reg_waddr; wdat_seen = bus.reg_wdat; cd = wdelay;
      end
      if (bus.handler_done) begin
        lat = t + 1; done = 1;
      end
      if (t == inject_t) begin
        bus.func_code = 8'h04; bus.addr = 16'h0007; bus.data = 16'h0063;
        bus.rx_message_done = 1'b1; bus.exception_in = 8'h02; bus.exception_done = 1'b1;
      end
      if (t == rst_t) begin
        rst_n = 1'b0; aborted = 1; done = 1;
      end
      t++;
    end
    if (!aborted) begin
      @(negedge clk);
      hd_w = int'(bus.handler_done);
    end
  endtask

  // Transaction-level model: outcome of one request from the protocol rules alone.
  task automatic model_txn(input int fc, input int a, input int d, input int ex,
                           input int wdelay, input bit wst);
    int n;
    exp_nwr = 0; exp_nwen = 0; exp_waddr = 0; exp_wdat = 0; exp_base = 0;
    exp_from_input = (fc == 4);
    if (ex != 0) begin
      exp_exc = ex; exp_lat = 1;
    end else if (fc != 3 && fc != 4 && fc != 6) begin
      exp_exc = 1; m_txq = 0; exp_lat = 2;
    end else if (fc == 6) begin
      if (a < 1 || a > NH) begin
        exp_exc = 2; m_txq = 0; exp_lat = 2;
      end else begin
        exp_exc = wst ? 4 : 0; m_txq = 0; exp_lat = 3 + wdelay;
        exp_nwen = 1; exp_waddr = a - 1; exp_wdat = d;
      end
    end else begin
      n = (fc == 3) ? NH : NI;
      if (d == 0 || d > n) begin
        exp_exc = 3; m_txq = 0; exp_lat = 2;
      end else if (a < 1 || a + d > 1 + n) begin
        exp_exc = 2; m_txq = 0; exp_lat = 2;
      end else begin
        exp_exc = 0; m_txq = d; exp_lat = d + 2; exp_nwr = d; exp_base = a - 1;
      end
    end
    exp_txq = m_txq;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] w;
    chk({tag, " exc"}, int'(bus.exception_out), exp_exc);
    chk({tag, " txq"}, int'(bus.tx_quantity), exp_txq);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " nwr"}, nwr, exp_nwr);
    chk({tag, " nwen"}, nwen, exp_nwen);
    chk({tag, " hd_width"}, hd_w, 0);
    if (exp_nwen != 0) begin
      chk({tag, " waddr"}, int'(waddr_seen), exp_waddr);
      chk({tag, " wdat"}, int'(wdat_seen), exp_wdat);
    end
    for (int i = 0; i < exp_nwr; i++) begin
      w = exp_from_input ? ireg[exp_base + i] : hreg[exp_base + i];
      chk($sformatf("%s word%0d", tag, i), int'(mem[i]), int'(w));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " exc"}, int'(bus.exception_out), 0);
    chk({tag, " txq"}, int'(bus.tx_quantity), 0);
    chk({tag, " fc_r"}, int'(bus.func_code_r), 0);
    chk({tag, " addr_r"}, int'(bus.addr_r), 0);
    chk({tag, " data_r"}, int'(bus.data_r), 0);
    chk({tag, " dpram_wen"}, int'(bus.dpram_wen), 0);
    chk({tag, " dpram_addr"}, int'(bus.dpram_addr), 0);
    chk({tag, " reg_wen"}, int'(bus.reg_wen), 0);
    chk({tag, " hd"}, int'(bus.handler_done), 0);
  endtask

  initial begin
    bit seen_hd;
    bus.rx_message_done = 1'b0; bus.func_code = 8'h0; bus.addr = 16'h0; bus.data = 16'h0;
    bus.exception_done = 1'b0; bus.exception_in = 8'h0;
    bus.reg_w_done = 1'b0; bus.reg_w_status = 1'b0;
    for (int k = 0; k < NH; k++) hreg[k] = 16'hA000 + 16'(k);
    for (int k = 0; k < NI; k++) ireg[k] = 16'hB000 + 16'(k);

    tbl[0]  = '{8'h03, 16'd3, 16'd4,     8'h00, 1'b0, 0, 4, 6,  4, 0, 16'hA002, 16'hA005};
    tbl[1]  = '{8'h04, 16'd1, 16'd8,     8'h00, 1'b0, 0, 8, 10, 8, 0, 16'hB000, 16'hB007};
    tbl[2]  = '{8'h04, 16'd2, 16'd8,     8'h00, 1'b0, 2, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[3]  = '{8'h03, 16'd1, 16'd0,     8'h00, 1'b0, 3, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[4]  = '{8'h03, 16'd1, 16'd9,     8'h00, 1'b0, 3, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[5]  = '{8'h05, 16'd1, 16'd1,     8'h00, 1'b0, 1, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[6]  = '{8'h03, 16'd3, 16'd4,     8'h02, 1'b0, 2, 0, 1,  0, 0, 16'h0,    16'h0};
    tbl[7]  = '{8'h06, 16'd5, 16'h1234,  8'h00, 1'b0, 0, 0, 4,  0, 1, 16'h0004, 16'h1234};
    tbl[8]  = '{8'h06, 16'd5, 16'hBEEF,  8'h00, 1'b1, 4, 0, 4,  0, 1, 16'h0004, 16'hBEEF};
    tbl[9]  = '{8'h06, 16'd9, 16'd1,     8'h00, 1'b0, 2, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[10] = '{8'h06, 16'd0, 16'd1,     8'h00, 1'b0, 2, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[11] = '{8'h03, 16'd8, 16'd1,     8'h00, 1'b0, 0, 1, 3,  1, 0, 16'hA007, 16'hA007};
    tbl[12] = '{8'h04, 16'd0, 16'd1,     8'h00, 1'b0, 2, 0, 2,  0, 0, 16'h0,    16'h0};
    tbl[13] = '{8'h03, 16'd1, 16'd8,     8'h00, 1'b0, 0, 8, 10, 8, 0, 16'hA000, 16'hA007};
    tbl[14] = '{8'h03, 16'd1, 16'd1,     8'h03, 1'b0, 3, 8, 1,  0, 0, 16'h0,    16'h0};

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 15; r++) begin
      string tag;
      tag = $sformatf("vec%0d", r);
      run_txn(tbl[r].fc, tbl[r].a, tbl[r].d, tbl[r].ex, 1, tbl[r].wst, -1, -1);
      model_txn(int'(tbl[r].fc), int'(tbl[r].a), int'(tbl[r].d), int'(tbl[r].ex), 1, tbl[r].wst);
      chk({tag, " exc"}, int'(bus.exception_out), tbl[r].e_exc);
      chk({tag, " txq"}, int'(bus.tx_quantity), tbl[r].e_txq);
      chk({tag, " lat"}, lat, tbl[r].e_lat);
      chk({tag, " nwr"}, nwr, tbl[r].e_nwr);
      chk({tag, " nwen"}, nwen, tbl[r].e_nwen);
      chk({tag, " hd_width"}, hd_w, 0);
      if (tbl[r].e_nwr > 0) begin
        chk({tag, " first"}, int'(mem[0]), int'(tbl[r].e_w0));
        chk({tag, " last"}, int'(mem[tbl[r].e_nwr - 1]), int'(tbl[r].e_w1));
      end
      if (tbl[r].e_nwen > 0) begin
        chk({tag, " waddr"}, int'(waddr_seen), int'(tbl[r].e_w0));
        chk({tag, " wdat"}, int'(wdat_seen), int'(tbl[r].e_w1));
      end
    end

    // New request fields and exception_done arriving mid-READ must be ignored.
    run_txn(8'h03, 16'd1, 16'd8, 8'h00, 1, 1'b0, 3, -1);
    model_txn(3, 1, 8, 0, 1, 1'b0);
    check_model("inject");
    chk("inject fc_r", int'(bus.func_code_r), 3);
    chk("inject addr_r", int'(bus.addr_r), 1);
    chk("inject data_r", int'(bus.data_r), 8);
    repeat (3) @(negedge clk);
    chk("inject idle", int'(bus.busy), 0);
    chk("inject exc_kept", int'(bus.exception_out), 0);

    // Reset mid-READ aborts without a handler_done pulse.
    run_txn(8'h03, 16'd1, 16'd8, 8'h00, 1, 1'b0, -1, 4);
    @(negedge clk);
    check_zero_outputs("midrst");
    rst_n = 1'b1;
    m_txq = 0;
    seen_hd = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.handler_done) seen_hd = 1;
    end
    chk("midrst no_hd", int'(seen_hd), 0);
    run_txn(8'h03, 16'd3, 16'd4, 8'h00, 1, 1'b0, -1, -1);
    model_txn(3, 3, 4, 0, 1, 1'b0);
    check_model("postrst");

`ifdef MODBUS_WR_TIMEOUT_EN
    // No reg_w_done: WRITE_WAIT gives up after 20 cycles with exception 04.
    run_txn(8'h06, 16'd5, 16'h0055, 8'h00, 0, 1'b0, -1, -1);
    model_txn(6, 5, 16'h0055, 0, 20, 1'b1);
    check_model("timeout");
    bus.reg_w_done = 1'b1;
    @(negedge clk);
    bus.reg_w_done = 1'b0;
    @(negedge clk);
    chk("late_done exc", int'(bus.exception_out), 4);
    chk("late_done idle", int'(bus.busy), 0);
`endif

    for (int k = 0; k < NH; k++) hreg[k] = 16'($urandom);
    for (int k = 0; k < NI; k++) ireg[k] = 16'($urandom);
    for (int n = 0; n < 80; n++) begin
      int sel, a, d, ex, wd;
      logic [7:0] fc;
      bit wst;
      sel = int'($urandom_range(0, 9));
      fc  = (sel < 4) ? 8'h03 : (sel < 7) ? 8'h04 : (sel < 9) ? 8'h06 : 8'($urandom);
      a   = int'($urandom_range(0, 10));
      d   = (fc == 8'h06) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 10));
      ex  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 11)) : 0;
      wd  = int'($urandom_range(1, 3));
      wst = 1'($urandom);
      run_txn(fc, 16'(a), 16'(d), 8'(ex), wd, wst, -1, -1);
      model_txn(int'(fc), a, d, ex, wd, wst);
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/modbus_func_engine.md
Name: modbus_func_engine

Overview:
Parametrised Modbus RTU function handler, successor to the fixed single-register handler. Sits between the frame receiver/validator and the response transmitter. Serves FC 0x03 from N_HOLD holding registers, FC 0x04 from N_INPUT input registers, and FC 0x06 via a write handshake. Address/quantity range checks are done locally, and read data is loaded into the TX dual-port RAM.

Parameters:
N_HOLD, 8, number of holding registers (1..125)
N_INPUT, 8, number of input registers (1..125)
HOLD_BASE, 16'h0001, Modbus address of holding register 0
INPUT_BASE, 16'h0001, Modbus address of input register 0
DPRAM_AW, 8, TX DPRAM address width
WR_TIMEOUT, 1000, cycles to wait for reg_w_done (used only with the optional feature)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  synchronous active-low reset
rx_message_done  input  1  pulse: func_code/addr/data valid
func_code  input  8  received function code
addr  input  16  start address
data  input  16  quantity (03/04) or write value (06)
exception_done  input  1  pulse: upstream check finished
exception_in  input  8  upstream exception code, 0 = none
hold_regs  input  16*N_HOLD  holding register values, reg k at [16k+15:16k]
input_regs  input  16*N_INPUT  input register values, same packing
tx_quantity  output  8  number of words written to DPRAM
exception_out  output  8  response exception code, 0 = normal
func_code_r  output  8  latched function code
addr_r  output  16  latched address
data_r  output  16  latched data
dpram_wen  output  1  DPRAM write enable
dpram_addr  output  DPRAM_AW  DPRAM word address
dpram_wdata  output  16  DPRAM write data
reg_wen  output  1  single-cycle write request
reg_waddr  output  16  holding-register index (addr_r - HOLD_BASE)
reg_wdat  output  16  write value
reg_w_done  input  1  write-complete pulse
reg_w_status  input  1  1 = write failed
handler_done  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst_n_in=0 at clock edge): all outputs 0, state IDLE, index counter 0.
- Latching: in IDLE, rx_message_done latches func_code/addr/data into *_r. rx_message_done outside IDLE is ignored and *_r is held.
- IDLE: on exception_done:
  - exception_in != 0: exception_out = exception_in, go to DONE.
  - exception_in == 0: go to CHECK.
  - dpram_wen and reg_wen stay 0 in IDLE.
- CHECK (1 cycle), with Q = data_r; all address arithmetic is 17 bits wide, no wrap:
  - Function code other than 03/04/06: exception 01.
  - 03/04 with Q == 0, or Q > N (N_HOLD or N_INPUT): exception 03.
  - 03/04 with addr_r < BASE, or addr_r + Q > BASE + N: exception 02.
  - 06 with addr_r outside [HOLD_BASE, HOLD_BASE + N_HOLD - 1]: exception 02.
  - On exception: set exception_out, tx_quantity = 0, go to DONE.
  - Otherwise: 03/04 go to READ with index = 0; 06 goes to WRITE_REQ.
- READ: one word per cycle.
  - dpram_wen = 1, dpram_addr = index, dpram_wdata = reg[addr_r - BASE + index].
  - After index Q-1: dpram_wen = 0, tx_quantity = Q, exception_out = 0, go to DONE.
  - dpram_wen is high for exactly Q consecutive cycles.
- WRITE_REQ: reg_wen = 1 for exactly one cycle with reg_waddr and reg_wdat = data_r, then WRITE_WAIT.
- WRITE_WAIT: on reg_w_done, exception_out = 04 if reg_w_status = 1, else 0; tx_quantity = 0; go to DONE.
  - reg_w_done seen in any other state is ignored.
- DONE: handler_done = 1 for one cycle, then IDLE. exception_out and tx_quantity hold until the next transaction updates them.
- Latency (read): exception_done at edge 0, CHECK at edge 1, DPRAM writes at edges 2..Q+1, handler_done at edge Q+2.
- exception_done while busy is ignored.
- Reset mid-operation aborts immediately, with no partial handler_done. The next transaction behaves normally.

Optional Feature:
MODBUS_WR_TIMEOUT_EN
- Defined: a 16-bit counter runs in WRITE_WAIT. If reg_w_done is not seen within WR_TIMEOUT cycles, exception_out = 04 and go to DONE. A late reg_w_done is ignored.
- Undefined: WRITE_WAIT waits indefinitely. No counter is synthesised.

Test Plan:
- Read holding: N_HOLD=8, regs k = 16'hA000+k, FC03 addr=3 Q=4 -> DPRAM addr 0..3 = A002..A005; tx_quantity=4; exception_out=0; handler_done at edge 6 after exception_done.
- Read input, boundary: FC04 addr=1 Q=8 -> 8 writes, last input reg at dpram_addr 7. FC04 addr=2 Q=8 -> exception 02, no dpram_wen.
- Quantity/function checks: FC03 Q=0 -> exception 03. FC03 Q=9 -> exception 03. FC05 -> exception 01. exception_in=02 upstream -> exception_out=02, handler_done 1 cycle later.
- Write: FC06 addr=5 data=16'h1234 -> reg_wen one cycle, reg_waddr=4, reg_wdat=1234. reg_w_done with status 0 -> exception 0; with status 1 -> exception 04.
- Robustness: rx_message_done with new fields during READ -> *_r unchanged. Reset asserted mid-READ -> all outputs 0, then a following FC03 completes correctly.
- Timeout (with MODBUS_WR_TIMEOUT_EN, WR_TIMEOUT=20): FC06 with no reg_w_done -> exception 04 and handler_done after 20 cycles in WRITE_WAIT.
